servo_pwm_array: RTL and testbench

Multi-channel hobby-servo PWM generator: the parametrised successor to the team's single-channel two-position servo driver. It drives CH servos from one shared frame counter. Each channel takes an arbitrary angle, 0–180°, over a valid/ready command port. Pulse widths change only at frame boundaries, so outputs are glitch-free. An optional slew-rate limiter ramps each channel toward its target.

---
 rtl/servo_pwm_array.sv | 120 ++++++++++++
 tb/tb_servo_pwm_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel widths that change only at frame boundaries.
// Define SERVO_SLEW_EN to compile in the per-frame slew-rate limiter (SLEW_CYC per frame per channel).
module servo_pwm_array #(
  parameter int PERIOD_CYC = 1_000_000,
  parameter int CH         = 4,
  parameter int MIN_CYC    = 25_000,
  parameter int DEG_CYC    = 555,
  parameter int RST_ANGLE  = 90,
  parameter int SLEW_CYC   = 5_550
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_ch,
  input  logic [7:0]    cmd_angle,
  output logic          cmd_err,
  output logic [CH-1:0] pwm,
  output logic [CH-1:0] at_target,
  output logic          frame_start
);

  localparam int               CNT_W    = $clog2(PERIOD_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_W    = CNT_W'(MIN_CYC + RST_ANGLE * DEG_CYC);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] DEG_W    = CNT_W'(DEG_CYC);
  localparam logic [4:0]       CH_NUM   = 5'(CH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q [CH];
  logic [CNT_W-1:0] tgt_d [CH];
  logic [CNT_W-1:0] cur_q [CH];
  logic [CNT_W-1:0] cur_d [CH];
  logic [CH-1:0]    pwm_q, pwm_d;
  logic [CH-1:0]    at_q, at_d;
  logic             fs_q, fs_d;
  logic             err_q, err_d;

  logic             update;
  logic             accept;
  logic             chOk;
  logic             angOver;
  logic [7:0]       angSat;
  logic [CNT_W-1:0] cmdW;

`ifdef SERVO_SLEW_EN
  localparam logic [CNT_W-1:0] SLEW_W = CNT_W'(SLEW_CYC);

  function automatic logic [CNT_W-1:0] stepToward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    if (tgt > cur) begin
      return (tgt - cur > SLEW_W) ? cur + SLEW_W : tgt;
    end else begin
      return (cur - tgt > SLEW_W) ? cur - SLEW_W : tgt;
    end
  endfunction
`endif

  // The update cycle is the only cycle commands are refused, so tgt_w never changes while cur_w samples it.
  assign update    = (cnt_q == LAST_CNT);
  assign cmd_ready = ~update;
  assign accept    = cmd_valid & cmd_ready;
  assign chOk      = ({1'b0, cmd_ch} < CH_NUM);
  assign angOver   = (cmd_angle > 8'd180);
  assign angSat    = angOver ? 8'd180 : cmd_angle;
  assign cmdW      = MIN_W + CNT_W'(angSat) * DEG_W;

  always_comb begin
    cnt_d = update ? '0 : cnt_q + CNT_W'(1);
    fs_d  = (cnt_q == '0);
    err_d = accept & (angOver | ~chOk);
    tgt_d = tgt_q;
    cur_d = cur_q;
    pwm_d = '0;
    at_d  = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = (cnt_q < cur_q[i]);
      at_d[i]  = (cur_q[i] == tgt_q[i]);
      if (accept && chOk && (cmd_ch == 4'(i))) begin
        tgt_d[i] = cmdW;
      end
      if (update) begin
`ifdef SERVO_SLEW_EN
        cur_d[i] = stepToward(cur_q[i], tgt_q[i]);
`else
        cur_d[i] = tgt_q[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= '0;
      at_q  <= '1;
      fs_q  <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        tgt_q[i] <= RST_W;
        cur_q[i] <= RST_W;
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      at_q  <= at_d;
      fs_q  <= fs_d;
      err_q <= err_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
    end
  end

  assign pwm         = pwm_q;
  assign at_target   = at_q;
  assign frame_start = fs_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array with a scaled-down frame (200 cycles, 1 cycle per degree).
// Honours SERVO_SLEW_EN the same way the design does.
module tb_servo_pwm_array;

  localparam int P     = 200;
  localparam int CH    = 4;
  localparam int MINC  = 10;
  localparam int DEG   = 1;
  localparam int RANG  = 90;
  localparam int SLEW  = 20;
  localparam int RSTW  = MINC + RANG * DEG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_ch = '0;
  logic [7:0]    cmd_angle = '0;
  logic          cmd_err;
  logic [CH-1:0] pwm;
  logic [CH-1:0] at_target;
  logic          frame_start;

  int vectors = 0;
  int miscompares = 0;
  bit chkEn = 1'b0;

  int            edges = 0;
  int            tgt [CH];
  int            cur [CH];
  logic [CH-1:0] expPwm = '0;
  logic [CH-1:0] expAt = '1;
  logic          expFs = 1'b0;
  logic          expErr = 1'b0;
  int            hiCnt [CH];

  servo_pwm_array #(
    .PERIOD_CYC(P),
    .CH(CH),
    .MIN_CYC(MINC),
    .DEG_CYC(DEG),
    .RST_ANGLE(RANG),
    .SLEW_CYC(SLEW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch),
    .cmd_angle(cmd_angle),
    .cmd_err(cmd_err),
    .pwm(pwm),
    .at_target(at_target),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: frame phase is the count of clean edges since reset, modulo the frame length.
  always @(posedge clk) begin
    int ph;
    int ang;
    int stp;
    int idx;
    if (rst) begin
      edges  = 0;
      expPwm = '0;
      expAt  = '1;
      expFs  = 1'b0;
      expErr = 1'b0;
      for (int i = 0; i < CH; i++) begin
        tgt[i] = RSTW;
        cur[i] = RSTW;
      end
    end else begin
      ph = edges % P;
      for (int i = 0; i < CH; i++) begin
        expPwm[i] = (ph < cur[i]);
        expAt[i]  = (cur[i] == tgt[i]);
      end
      expFs  = (ph == 0);
      expErr = 1'b0;
      if (ph == P - 1) begin
        for (int i = 0; i < CH; i++) begin
`ifdef SERVO_SLEW_EN
          stp = tgt[i] - cur[i];
          if (stp > SLEW)  stp = SLEW;
          if (stp < -SLEW) stp = -SLEW;
          cur[i] = cur[i] + stp;
`else
          cur[i] = tgt[i];
`endif
        end
      end else if (cmd_valid) begin
        ang = (cmd_angle > 8'd180) ? 180 : int'(cmd_angle);
        idx = int'(cmd_ch);
        if (idx < CH) tgt[idx] = MINC + ang * DEG;
        expErr = (cmd_angle > 8'd180) || (idx >= CH);
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("pwm", int'(pwm), int'(expPwm));
      checkOutput("at_target", int'(at_target), int'(expAt));
      checkOutput("frame_start", int'(frame_start), int'(expFs));
      checkOutput("cmd_err", int'(cmd_err), int'(expErr));
      checkOutput("cmd_ready", int'(cmd_ready), int'((edges % P) != P - 1));
    end
  end

  task automatic applyStimulus(input int ch, input int ang);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ch    = ch[3:0];
    cmd_angle = ang[7:0];
    while (!cmd_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts high cycles per channel over one full frame, starting at a frame_start pulse.
  task automatic measureFrame();
    int n;
    n = 0;
    for (int i = 0; i < CH; i++) hiCnt[i] = 0;
    while (!frame_start && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) checkOutput("frameStartTimeout", 0, 1);
    for (int c = 0; c < P; c++) begin
      for (int i = 0; i < CH; i++) hiCnt[i] += int'(pwm[i]);
      @(negedge clk);
    end
  endtask

  task automatic waitPhase(input int ph);
    int n;
    n = 0;
    @(negedge clk);
    while ((edges % P) != ph && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    if ((edges % P) != ph) checkOutput("phaseTimeout", edges % P, ph);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rstPwm", int'(pwm), 0);
    checkOutput("rstAtTarget", int'(at_target), 15);
    checkOutput("rstReady", int'(cmd_ready), 1);
    checkOutput("rstErr", int'(cmd_err), 0);
    checkOutput("rstFrameStart", int'(frame_start), 0);
    chkEn = 1'b1;
    rst   = 1'b0;

    measureFrame();
    for (int i = 0; i < CH; i++) checkOutput($sformatf("idleWidth%0d", i), hiCnt[i], 100);

    repeat (50) @(negedge clk);
    applyStimulus(0, 0);
    measureFrame();
`ifdef SERVO_SLEW_EN
    checkOutput("ch0NextFrame", hiCnt[0], 80);
`else
    checkOutput("ch0NextFrame", hiCnt[0], 10);
`endif
    for (int i = 1; i < CH; i++) checkOutput($sformatf("othersUnchanged%0d", i), hiCnt[i], 100);

    applyStimulus(2, 200);
    checkOutput("clampErr", int'(cmd_err), 1);
    applyStimulus(9, 30);
    checkOutput("badChErr", int'(cmd_err), 1);
    repeat (6 * P) @(negedge clk);
    measureFrame();
    checkOutput("settledCh0", hiCnt[0], 10);
    checkOutput("settledCh1", hiCnt[1], 100);
    checkOutput("settledCh2", hiCnt[2], 190);
    checkOutput("settledCh3", hiCnt[3], 100);

    waitPhase(P - 1);
    checkOutput("readyLowOnUpdate", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_ch    = 4'd3;
    cmd_angle = 8'd45;
    @(negedge clk);
    checkOutput("readyAfterUpdate", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4 * P) @(negedge clk);
    measureFrame();
    checkOutput("heldCmdCh3", hiCnt[3], 55);

`ifdef SERVO_SLEW_EN
    applyStimulus(1, 0);
    measureFrame();
    checkOutput("slewStep1", hiCnt[1], 80);
    measureFrame();
    checkOutput("slewStep2", hiCnt[1], 60);
    measureFrame();
    checkOutput("slewStep3", hiCnt[1], 40);
    measureFrame();
    checkOutput("slewStep4", hiCnt[1], 20);
    measureFrame();
    checkOutput("slewStep5", hiCnt[1], 10);
    repeat (2) @(negedge clk);
    checkOutput("slewAtTarget", int'(at_target[1]), 1);
`endif

    waitPhase(40);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetPwm", int'(pwm), 0);
    rst = 1'b0;
    measureFrame();
    for (int i = 0; i < CH; i++) checkOutput($sformatf("postResetWidth%0d", i), hiCnt[i], 100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
